// File: rtl/cache_pkg.sv
// Shared types and default widths for the two-way set controller.
package cache_pkg;

    localparam int unsigned TAG_W      = 5;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned WORD_W     = 2;
    localparam int unsigned LINE_WORDS = 2 ** WORD_W;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWb,
        StRefill,
        StFlush
    } state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim selection for a two-way set (invalid way first, else LRU) and the LRU bit itself.
module cache_victim_sel (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] way_valid_i,
    input  logic [1:0] way_dirty_i,
    input  logic       lru_upd_i,
    input  logic       lru_val_i,
    input  logic       lru_clr_i,
    output logic       victim_o,
    output logic       victim_dirty_o
);

    logic lru_q;

    always_comb begin
        if (!way_valid_i[0]) begin
            victim_o = 1'b0;
        end else if (!way_valid_i[1]) begin
            victim_o = 1'b1;
        end else begin
            victim_o = lru_q;
        end
    end

    assign victim_dirty_o = way_valid_i[victim_o] & way_dirty_i[victim_o];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lru_q <= 1'b0;
        end else if (lru_clr_i) begin
            lru_q <= 1'b0;
        end else if (lru_upd_i) begin
            lru_q <= lru_val_i;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Two-way set controller: CPU handshake, hit/miss handling, writeback, refill and flush.
module cache_ctrl #(
    parameter int unsigned TAG_W  = cache_pkg::TAG_W,
    parameter int unsigned DATA_W = cache_pkg::DATA_W,
    parameter int unsigned WORD_W = cache_pkg::WORD_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_wr_i,
    input  logic                    cpu_flush_i,
    input  logic [TAG_W-1:0]        cpu_tag_i,
    input  logic [WORD_W-1:0]       cpu_word_i,
    input  logic [DATA_W-1:0]       cpu_wdata_i,
    output logic [DATA_W-1:0]       cpu_rdata_o,
    output logic                    cpu_ready_o,
    output logic [1:0]              way_en_o,
    output logic                    way_cmp_o,
    output logic                    way_write_o,
    output logic                    way_valid_in_o,
    output logic                    way_rst_o,
    output logic [WORD_W-1:0]       way_word_o,
    output logic [TAG_W-1:0]        way_tag_o,
    output logic [DATA_W-1:0]       way_din_o,
    input  logic [1:0]              way_hit_i,
    input  logic [1:0]              way_dirty_i,
    input  logic [1:0]              way_valid_i,
    input  logic [1:0]              way_ack_i,
    input  logic [TAG_W-1:0]        way0_tag_out_i,
    input  logic [TAG_W-1:0]        way1_tag_out_i,
    input  logic [DATA_W-1:0]       way0_dout_i,
    input  logic [DATA_W-1:0]       way1_dout_i,
    output logic                    mem_req_o,
    output logic                    mem_wr_o,
    output logic [TAG_W+WORD_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_ack_i
);

    import cache_pkg::*;

    state_e              state_q;
    logic                req_wr_q;
    logic [TAG_W-1:0]    req_tag_q;
    logic [WORD_W-1:0]   req_word_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [WORD_W-1:0]   cnt_q;
    logic                victim_q;
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          ack_seen_q;

    logic                hit;
    logic                hit_way;
    logic [DATA_W-1:0]   hit_dout;
    logic [TAG_W-1:0]    vic_tag;
    logic [DATA_W-1:0]   vic_dout;
    logic [1:0]          vic_en;
    logic                victim;
    logic                victim_dirty;
    logic                flush_done;
    logic                lru_upd;
    logic                lru_clr;

    // Both hit bits set is illegal; resolve it as a hit in way0.
    assign hit        = |way_hit_i;
    assign hit_way    = ~way_hit_i[0];
    assign hit_dout   = hit_way ? way1_dout_i : way0_dout_i;
    assign vic_tag    = victim_q ? way1_tag_out_i : way0_tag_out_i;
    assign vic_dout   = victim_q ? way1_dout_i : way0_dout_i;
    assign vic_en     = victim_q ? 2'b10 : 2'b01;
    assign flush_done = &(ack_seen_q | way_ack_i);
    assign lru_upd    = (state_q == StCompare) && hit;
    assign lru_clr    = (state_q == StFlush) && flush_done;

    cache_victim_sel u_victim_sel (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .way_valid_i    (way_valid_i),
        .way_dirty_i    (way_dirty_i),
        .lru_upd_i      (lru_upd),
        .lru_val_i      (~hit_way),
        .lru_clr_i      (lru_clr),
        .victim_o       (victim),
        .victim_dirty_o (victim_dirty)
    );

    // Way and memory pins are decoded from state: the ways answer in the same cycle.
    always_comb begin
        way_en_o       = 2'b00;
        way_cmp_o      = 1'b0;
        way_write_o    = 1'b0;
        way_valid_in_o = 1'b0;
        way_rst_o      = 1'b0;
        way_word_o     = '0;
        way_tag_o      = '0;
        way_din_o      = '0;
        mem_req_o      = 1'b0;
        mem_wr_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        unique case (state_q)
            StCompare: begin
                way_en_o       = 2'b11;
                way_cmp_o      = 1'b1;
                way_write_o    = req_wr_q;
                way_valid_in_o = 1'b1;
                way_tag_o      = req_tag_q;
                way_word_o     = req_word_q;
                way_din_o      = req_wdata_q;
            end
            StWb: begin
                way_en_o    = vic_en;
                way_word_o  = cnt_q;
                mem_req_o   = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = {vic_tag, cnt_q};
                mem_wdata_o = vic_dout;
            end
            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag_q, cnt_q};
                if (mem_ack_i) begin
                    way_en_o       = vic_en;
                    way_write_o    = 1'b1;
                    way_valid_in_o = 1'b1;
                    way_tag_o      = req_tag_q;
                    way_word_o     = cnt_q;
                    way_din_o      = mem_rdata_i;
                end
            end
            StFlush: begin
                way_en_o  = 2'b11;
                way_rst_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            req_wr_q    <= 1'b0;
            req_tag_q   <= '0;
            req_word_q  <= '0;
            req_wdata_q <= '0;
            cnt_q       <= '0;
            victim_q    <= 1'b0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            ack_seen_q  <= 2'b00;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The request is still held during the ready pulse; do not re-accept it.
                    if (!ready_q) begin
                        if (cpu_flush_i) begin
                            state_q <= StFlush;
                        end else if (cpu_req_i) begin
                            req_wr_q    <= cpu_wr_i;
                            req_tag_q   <= cpu_tag_i;
                            req_word_q  <= cpu_word_i;
                            req_wdata_q <= cpu_wdata_i;
                            state_q     <= StCompare;
                        end
                    end
                end
                StCompare: begin
                    if (hit) begin
                        ready_q <= 1'b1;
                        if (!req_wr_q) begin
                            rdata_q <= hit_dout;
                        end
                        state_q <= StIdle;
                    end else begin
                        victim_q <= victim;
                        cnt_q    <= '0;
                        state_q  <= victim_dirty ? StWb : StRefill;
                    end
                end
                StWb: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + WORD_W'(1);
                        if (cnt_q == '1) begin
                            state_q <= StRefill;
                        end
                    end
                end
                StRefill: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + WORD_W'(1);
                        if (cnt_q == '1) begin
                            state_q <= StCompare;
                        end
                    end
                end
                StFlush: begin
                    ack_seen_q <= ack_seen_q | way_ack_i;
                    if (flush_done) begin
                        ack_seen_q <= 2'b00;
                        ready_q    <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_ready_o = ready_q;
    assign cpu_rdata_o = rdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural ways and memory, plus a line-level reference model of the set.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wr, cpu_flush;
    logic [4:0]  cpu_tag;
    logic [1:0]  cpu_word;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic [1:0]  way_en;
    logic        way_cmp, way_write, way_valid_in, way_rst;
    logic [1:0]  way_word;
    logic [4:0]  way_tag;
    logic [15:0] way_din;
    logic [1:0]  way_hit, way_dirty, way_valid, way_ack;
    logic [4:0]  way0_tag_out, way1_tag_out;
    logic [15:0] way0_dout, way1_dout;
    logic        mem_req, mem_wr, mem_ack;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_req_i      (cpu_req),
        .cpu_wr_i       (cpu_wr),
        .cpu_flush_i    (cpu_flush),
        .cpu_tag_i      (cpu_tag),
        .cpu_word_i     (cpu_word),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_rdata_o    (cpu_rdata),
        .cpu_ready_o    (cpu_ready),
        .way_en_o       (way_en),
        .way_cmp_o      (way_cmp),
        .way_write_o    (way_write),
        .way_valid_in_o (way_valid_in),
        .way_rst_o      (way_rst),
        .way_word_o     (way_word),
        .way_tag_o      (way_tag),
        .way_din_o      (way_din),
        .way_hit_i      (way_hit),
        .way_dirty_i    (way_dirty),
        .way_valid_i    (way_valid),
        .way_ack_i      (way_ack),
        .way0_tag_out_i (way0_tag_out),
        .way1_tag_out_i (way1_tag_out),
        .way0_dout_i    (way0_dout),
        .way1_dout_i    (way1_dout),
        .mem_req_o      (mem_req),
        .mem_wr_o       (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_ack_i      (mem_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural ways ----------------
    logic        wv[2], wdty[2];
    logic [4:0]  wt[2];
    logic [15:0] wdat[2][LINE_WORDS];
    int          ack_dly[2];
    int          rst_cyc[2];

    assign way_hit = {way_en[1] && way_cmp && wv[1] && (wt[1] == way_tag),
                      way_en[0] && way_cmp && wv[0] && (wt[0] == way_tag)};
    assign way_ack = {way_en[1] && way_rst && (rst_cyc[1] == ack_dly[1]),
                      way_en[0] && way_rst && (rst_cyc[0] == ack_dly[0])};
    assign way_valid    = {wv[1], wv[0]};
    assign way_dirty    = {wdty[1], wdty[0]};
    assign way0_tag_out = wt[0];
    assign way1_tag_out = wt[1];
    assign way0_dout    = wdat[0][way_word];
    assign way1_dout    = wdat[1][way_word];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wv[i] <= 1'b0; wdty[i] <= 1'b0; rst_cyc[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (way_en[i] && way_rst) begin
                    rst_cyc[i] <= rst_cyc[i] + 1;
                    if (way_ack[i]) begin
                        wv[i] <= 1'b0; wdty[i] <= 1'b0;
                    end
                end else begin
                    rst_cyc[i] <= 0;
                end
                if (way_en[i] && way_write && !way_rst) begin
                    if (way_cmp) begin
                        if (way_hit[i]) begin
                            wdat[i][way_word] <= way_din; wdty[i] <= 1'b1;
                        end
                    end else begin
                        wdat[i][way_word] <= way_din; wt[i] <= way_tag;
                        wv[i] <= way_valid_in; wdty[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- behavioural memory ----------------
    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic [15:0] mem[128];
    int          mem_dly;
    int          mcyc = 0;
    logic        stray;
    txn_t        log_q[$];
    bit          stab_en;
    logic        prev_wait = 1'b0;
    logic [6:0]  prev_addr;
    logic [15:0] prev_wd;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (mem_req && (mcyc >= mem_dly)) || stray;

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            mcyc <= 0;
        end else if (mem_req) begin
            mcyc <= mcyc + 1;
        end else begin
            mcyc <= 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req && mem_ack)
            log_q.push_back('{wr: mem_wr, addr: mem_addr, data: (mem_wr ? mem_wdata : mem_rdata)});
        if (stab_en && prev_wait) begin
            check("stable_req", 32'(mem_req), 32'd1);
            check("stable_addr", 32'(mem_addr), 32'(prev_addr));
            if (mem_wr) check("stable_wdata", 32'(mem_wdata), 32'(prev_wd));
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_wd   = mem_wdata;
    end

    // ---------------- reference model: whole lines, plain arrays ----------------
    logic        rv[2], rdy[2];
    logic [4:0]  rt[2];
    logic [15:0] rdat[2][LINE_WORDS];
    logic        rlru;
    logic [15:0] rmem[128];
    txn_t        exp_q[$];

    task automatic ref_reset();
        for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rdy[i] = 1'b0; end
        rlru = 1'b0;
        exp_q.delete();
    endtask

    task automatic ref_access(input logic wr, input logic [4:0] tag, input logic [1:0] word,
                              input logic [15:0] wd, output logic [15:0] rd);
        int h, v;
        logic [6:0] a;
        exp_q.delete();
        h  = -1;
        rd = '0;
        for (int i = 1; i >= 0; i--) if (rv[i] && rt[i] == tag) h = i;
        if (h < 0) begin
            v = !rv[0] ? 0 : (!rv[1] ? 1 : (rlru ? 1 : 0));
            if (rv[v] && rdy[v]) begin
                for (int w = 0; w < LINE_WORDS; w++) begin
                    a = {rt[v], w[1:0]};
                    rmem[a] = rdat[v][w];
                    exp_q.push_back('{wr: 1'b1, addr: a, data: rdat[v][w]});
                end
            end
            for (int w = 0; w < LINE_WORDS; w++) begin
                a = {tag, w[1:0]};
                rdat[v][w] = rmem[a];
                exp_q.push_back('{wr: 1'b0, addr: a, data: rmem[a]});
            end
            rv[v] = 1'b1; rt[v] = tag; rdy[v] = 1'b0; h = v;
        end
        if (wr) begin rdat[h][word] = wd; rdy[h] = 1'b1; end
        else rd = rdat[h][word];
        rlru = (h == 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic fl, input logic wr, input logic [4:0] tag,
                          input logic [1:0] word, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        log_q.delete();
        @(negedge clk);
        cpu_flush = fl; cpu_req = !fl; cpu_wr = wr;
        cpu_tag = tag; cpu_word = word; cpu_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!cpu_ready && lat < 400);
        check("ready_seen", 32'(cpu_ready), 32'd1);
        rd = cpu_rdata;
        cpu_req = 1'b0; cpu_flush = 1'b0;
        @(posedge clk); #1;
        check("ready_one_pulse", 32'(cpu_ready), 32'd0);
    endtask

    task automatic cmp_txns();
        check("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check("txn_wr", 32'(log_q[i].wr), 32'(exp_q[i].wr));
            check("txn_addr", 32'(log_q[i].addr), 32'(exp_q[i].addr));
            check("txn_data", 32'(log_q[i].data), 32'(exp_q[i].data));
        end
    endtask

    task automatic run_op(input logic fl, input logic wr, input logic [4:0] tag,
                          input logic [1:0] word, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        logic [15:0] mrd;
        mrd = '0;
        if (fl) begin
            ref_reset();
        end else begin
            ref_access(wr, tag, word, wd, mrd);
        end
        access(fl, wr, tag, word, wd, rd, lat);
        cmp_txns();
        if (!fl && !wr) check("rdata_model", 32'(rd), 32'(mrd));
    endtask

    typedef struct {
        logic        fl;
        logic        wr;
        logic [4:0]  tag;
        logic [1:0]  word;
        logic [15:0] wd;
        logic        chk_rd;
        logic [15:0] exp_rd;
        int          ad0, ad1;
        int          exp_rf, exp_wb, exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] rd;
        int lat, nr, nw, n;
        logic [4:0] pool[4];

        for (int a = 0; a < 128; a++) mem[a] = 16'h1000 + 16'(a);
        mem[7'h77] = 16'h0F0F;
        for (int a = 0; a < 128; a++) rmem[a] = mem[a];
        rst = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_flush = 1'b0;
        cpu_tag = '0; cpu_word = '0; cpu_wdata = '0;
        stray = 1'b0; stab_en = 1'b0; mem_dly = 0;
        ack_dly[0] = 0; ack_dly[1] = 0;
        #1 rst = 1'b1;
        #20;
        check("reset_outputs", 32'({cpu_ready, cpu_rdata, way_en, way_cmp, way_write,
                                     way_rst, mem_req, mem_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_reset();

        //          fl    wr    tag     wd        chk   exp_rd    ad0 ad1 rf wb lat
        vecs[0] = '{1'b1, 1'b0, 5'h00, 2'd0, 16'h0000, 1'b0, 16'h0000, 0, 0, 0, 0, 2};
        vecs[1] = '{1'b0, 1'b0, 5'h1D, 2'd3, 16'h0000, 1'b1, 16'h0F0F, 0, 0, 4, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 5'h1D, 2'd3, 16'h0000, 1'b1, 16'h0F0F, 0, 0, 0, 0, 2};
        vecs[3] = '{1'b0, 1'b1, 5'h1D, 2'd1, 16'hA5A5, 1'b0, 16'h0000, 0, 0, 0, 0, 2};
        vecs[4] = '{1'b0, 1'b0, 5'h03, 2'd0, 16'h0000, 1'b1, 16'h100C, 0, 0, 4, 0, 0};
        vecs[5] = '{1'b0, 1'b0, 5'h0A, 2'd2, 16'h0000, 1'b1, 16'h102A, 0, 0, 4, 4, 0};
        vecs[6] = '{1'b0, 1'b0, 5'h1D, 2'd1, 16'h0000, 1'b1, 16'hA5A5, 0, 0, 4, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 5'h00, 2'd0, 16'h0000, 1'b0, 16'h0000, 1, 4, 0, 0, 6};
        vecs[8] = '{1'b0, 1'b0, 5'h1D, 2'd3, 16'h0000, 1'b1, 16'h0F0F, 0, 0, 4, 0, 0};

        for (int i = 0; i < 9; i++) begin
            ack_dly[0] = vecs[i].ad0; ack_dly[1] = vecs[i].ad1;
            run_op(vecs[i].fl, vecs[i].wr, vecs[i].tag, vecs[i].word, vecs[i].wd, rd, lat);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
            nr = 0; nw = 0;
            foreach (log_q[k]) if (log_q[k].wr) nw++; else nr++;
            check($sformatf("vec%0d_refills", i), 32'(nr), 32'(vecs[i].exp_rf));
            check($sformatf("vec%0d_writebacks", i), 32'(nw), 32'(vecs[i].exp_wb));
            if (vecs[i].exp_lat > 0) check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (i == 5 && log_q.size() > 1) check("wb_word1_data", 32'(log_q[1].data), 32'h0000A5A5);
        end
        ack_dly[0] = 0; ack_dly[1] = 0;

        // Stray acks while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stray = 1'b1;
            @(posedge clk); #1;
            check("stray_ack_no_req", 32'({mem_req, cpu_ready, way_en}), 32'd0);
        end
        @(negedge clk); stray = 1'b0;

        // Reset in the middle of a refill, at word 2.
        mem_dly = 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_tag = 5'h16; cpu_word = 2'd0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(mem_req && !mem_wr && mem_addr[1:0] == 2'd2) && n < 200);
        check("reached_refill_cnt2", 32'(n < 200), 32'd1);
        rst = 1'b1;
        #1;
        check("midreset_outputs", 32'({cpu_ready, way_en, way_write, way_valid_in, mem_req,
                                        mem_wr, mem_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        ref_reset();
        mem_dly = 0;
        run_op(1'b0, 1'b0, 5'h16, 2'd0, 16'h0, rd, lat);
        check("restart_first_addr", 32'(log_q.size() > 0 ? log_q[0].addr : 7'h7F), 32'h58);
        check("restart_rdata", 32'(rd), 32'h1058);

        // Slow memory: every transfer waits 5 cycles, outputs must hold still.
        mem_dly = 5; stab_en = 1'b1;
        run_op(1'b1, 1'b0, 5'h00, 2'd0, 16'h0, rd, lat);
        run_op(1'b0, 1'b1, 5'h01, 2'd2, 16'h1234, rd, lat);
        run_op(1'b0, 1'b1, 5'h02, 2'd0, 16'h5678, rd, lat);
        run_op(1'b0, 1'b0, 5'h04, 2'd1, 16'h0, rd, lat);
        check("slow_txns", 32'(log_q.size()), 32'd8);
        stab_en = 1'b0;

        // Random traffic over a small tag pool so hits, misses and evictions all occur.
        pool[0] = 5'h1D; pool[1] = 5'h03; pool[2] = 5'h0A; pool[3] = 5'h11;
        for (int i = 0; i < 150; i++) begin
            mem_dly    = $urandom_range(0, 3);
            ack_dly[0] = $urandom_range(0, 3);
            ack_dly[1] = $urandom_range(0, 3);
            run_op($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                   pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
                   16'($urandom), rd, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
